// File: rtl/irq_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_pkg : shared sizes and state type for the interrupt arbiter (rev 1.0) |
// +--------------------------------------------------------------------------+
package irq_pkg;

  localparam int N_REQ = 8;
  localparam int ID_W  = 3;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PRESENT = 2'd1,
    SERVICE = 2'd2
  } irq_state_t;

endpackage
`default_nettype wire

// File: rtl/irq_prio_enc.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_prio_enc : highest-set-bit index encoder, 0 on empty input (rev 1.0) |
// +--------------------------------------------------------------------------+
module irq_prio_enc
  import irq_pkg::*;
(
  input  logic [N_REQ-1:0] vec_i,
  output logic [ID_W-1:0]  idx_o,
  output logic             any_o
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (vec_i[i]) idx_o = ID_W'(i);
    end
  end

  assign any_o = |vec_i;

endmodule
`default_nettype wire

// File: rtl/irq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | irq_arbiter : edge-pending 8-line interrupt front-end, valid/ack + EOI    |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module irq_arbiter
  import irq_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req_in,
  input  logic [N_REQ-1:0] mask,
  input  logic             irq_ack,
  input  logic             eoi,
  output logic             irq_valid,
  output logic [ID_W-1:0]  irq_id,
  output logic             in_service,
  output logic [N_REQ-1:0] pending_o
);

  irq_state_t       state_q;
  logic [N_REQ-1:0] req_prev_q;
  logic [N_REQ-1:0] pending_q;
  logic [N_REQ-1:0] pending_d;
  logic             irq_valid_q;
  logic             in_service_q;
  logic [ID_W-1:0]  irq_id_q;

  logic [N_REQ-1:0] set_w;
  logic [N_REQ-1:0] clr_w;
  logic [N_REQ-1:0] elig_w;
  logic [ID_W-1:0]  win_idx_w;
  logic             win_any_w;

  assign set_w  = req_in & ~req_prev_q;
  assign elig_w = pending_q & ~mask;

  always_comb begin
    clr_w = '0;
    if (state_q == PRESENT && irq_ack) clr_w[irq_id_q] = 1'b1;
  end

  // A fresh edge on the line being acked re-pends it: set is OR-ed last.
  assign pending_d = (pending_q & ~clr_w) | set_w;

  irq_prio_enc u_prio_enc (
    .vec_i (elig_w),
    .idx_o (win_idx_w),
    .any_o (win_any_w)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      req_prev_q   <= '0;
      pending_q    <= '0;
      irq_valid_q  <= 1'b0;
      in_service_q <= 1'b0;
      irq_id_q     <= '0;
    end else begin
      req_prev_q <= req_in;
      pending_q  <= pending_d;
      case (state_q)
        IDLE: begin
          if (win_any_w) begin
            irq_id_q    <= win_idx_w;
            irq_valid_q <= 1'b1;
            state_q     <= PRESENT;
          end
        end
        PRESENT: begin
          // eoi in the same cycle is deliberately ignored.
          if (irq_ack) begin
            irq_valid_q  <= 1'b0;
            in_service_q <= 1'b1;
            state_q      <= SERVICE;
          end
        end
        SERVICE: begin
          if (eoi) begin
            in_service_q <= 1'b0;
            state_q      <= IDLE;
          end
        end
        default: begin
          irq_valid_q  <= 1'b0;
          in_service_q <= 1'b0;
          state_q      <= IDLE;
        end
      endcase
    end
  end

  assign irq_valid  = irq_valid_q;
  assign irq_id     = irq_id_q;
  assign in_service = in_service_q;
  assign pending_o  = pending_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_arbiter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_irq_arbiter : directed + random bench against a behavioural model     |
// | rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_irq_arbiter;

  logic       clk;
  logic       rst;
  logic [7:0] req_in;
  logic [7:0] mask;
  logic       irq_ack;
  logic       eoi;
  logic       irq_valid;
  logic [2:0] irq_id;
  logic       in_service;
  logic [7:0] pending_o;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Behavioural model: an interrupt is either being offered, being served,
  // or neither; pending lines are a plain array of flags.
  bit [7:0] m_prev;
  bit       m_pend [8];
  bit       m_offering;
  bit       m_serving;
  int       m_id;

  irq_arbiter dut (
    .clk        (clk),
    .rst        (rst),
    .req_in     (req_in),
    .mask       (mask),
    .irq_ack    (irq_ack),
    .eoi        (eoi),
    .irq_valid  (irq_valid),
    .irq_id     (irq_id),
    .in_service (in_service),
    .pending_o  (pending_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit [7:0] model_pend_vec();
    bit [7:0] v = '0;
    for (int i = 0; i < 8; i++) v[i] = m_pend[i];
    return v;
  endfunction

  task automatic model_update();
    int best;
    if (rst) begin
      m_prev = '0;
      for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
      m_offering = 1'b0;
      m_serving  = 1'b0;
      m_id       = 0;
      return;
    end
    if (m_offering) begin
      if (irq_ack) begin
        m_pend[m_id] = 1'b0;
        m_offering   = 1'b0;
        m_serving    = 1'b1;
      end
    end else if (m_serving) begin
      if (eoi) m_serving = 1'b0;
    end else begin
      best = -1;
      for (int i = 7; i >= 0; i--) begin
        if (best < 0 && m_pend[i] && !mask[i]) best = i;
      end
      if (best >= 0) begin
        m_id       = best;
        m_offering = 1'b1;
      end
    end
    // New rising edges land after the clear, so a same-cycle edge re-pends.
    for (int i = 0; i < 8; i++) begin
      if (req_in[i] && !m_prev[i]) m_pend[i] = 1'b1;
    end
    m_prev = req_in;
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check_val("model.valid",   32'(irq_valid),  32'(m_offering));
    check_val("model.insvc",   32'(in_service), 32'(m_serving));
    check_val("model.id",      32'(irq_id),     32'(m_id));
    check_val("model.pending", 32'(pending_o),  32'(model_pend_vec()));
  endtask

  task automatic pulse_ack();
    irq_ack = 1'b1; step(); irq_ack = 1'b0;
  endtask

  task automatic pulse_eoi();
    eoi = 1'b1; step(); eoi = 1'b0;
  endtask

  initial begin
    rst = 1'b1; req_in = '0; mask = '0; irq_ack = 1'b0; eoi = 1'b0;
    step();
    check_val("rst.valid",   32'(irq_valid),  0);
    check_val("rst.id",      32'(irq_id),     0);
    check_val("rst.insvc",   32'(in_service), 0);
    check_val("rst.pending", 32'(pending_o),  0);
    rst = 1'b0;
    step();

    // Single request on line 1: latency and handshake.
    req_in = 8'h02; step();
    check_val("s1.pend_e0",  32'(pending_o), 32'h02);
    check_val("s1.valid_e0", 32'(irq_valid), 0);
    step();
    check_val("s1.valid_e1", 32'(irq_valid), 1);
    check_val("s1.id_e1",    32'(irq_id),    1);
    pulse_ack();
    check_val("s1.pend_ack", 32'(pending_o),  32'h00);
    check_val("s1.insvc",    32'(in_service), 1);
    pulse_eoi();
    check_val("s1.eoi",      32'(in_service), 0);
    req_in = 8'h00; step();

    // Two simultaneous edges: highest index first.
    req_in = 8'h81; step(); step();
    check_val("s2.id7", 32'(irq_id), 7);
    pulse_ack(); pulse_eoi(); step();
    check_val("s2.id0",   32'(irq_id),    0);
    check_val("s2.pend1", 32'(pending_o), 32'h01);
    pulse_ack(); pulse_eoi();
    req_in = 8'h00; step();

    // Masked high line keeps pending; unmasking makes it win later.
    mask = 8'h80; req_in = 8'h90; step(); step();
    check_val("s3.id4",   32'(irq_id),    4);
    check_val("s3.pend",  32'(pending_o), 32'h90);
    pulse_ack(); pulse_eoi();
    mask = 8'h00; step();
    check_val("s3.id7",   32'(irq_id),    7);
    check_val("s3.valid", 32'(irq_valid), 1);
    pulse_ack(); pulse_eoi();
    req_in = 8'h00; step();

    // Higher-priority arrival during PRESENT does not displace the offer.
    req_in = 8'h04; step(); step();
    req_in = 8'h44; step();
    check_val("s4.id_hold", 32'(irq_id),    2);
    check_val("s4.pend",    32'(pending_o), 32'h44);
    pulse_ack(); pulse_eoi(); step();
    check_val("s4.id6", 32'(irq_id), 6);
    pulse_ack(); pulse_eoi();
    req_in = 8'h00; step();

    // Edge on the acked line in the ack cycle re-pends it.
    req_in = 8'h08; step(); step();
    check_val("s5.id3", 32'(irq_id), 3);
    req_in = 8'h00; step();
    req_in = 8'h08; pulse_ack();
    check_val("s5.pend3", 32'(pending_o[3]), 1);
    pulse_eoi(); step();
    check_val("s5.re_valid", 32'(irq_valid), 1);
    check_val("s5.re_id",    32'(irq_id),    3);
    pulse_ack(); pulse_eoi();
    req_in = 8'h00; step();

    // Stray eoi in IDLE, stray ack in SERVICE, then reset mid-service.
    pulse_eoi();
    check_val("s6.idle_valid", 32'(irq_valid),  0);
    check_val("s6.idle_insvc", 32'(in_service), 0);
    req_in = 8'h01; step(); step(); pulse_ack();
    pulse_ack();
    check_val("s6.svc_hold", 32'(in_service), 1);
    rst = 1'b1; step();
    check_val("s6.rst_valid", 32'(irq_valid),  0);
    check_val("s6.rst_id",    32'(irq_id),     0);
    check_val("s6.rst_insvc", 32'(in_service), 0);
    check_val("s6.rst_pend",  32'(pending_o),  0);
    rst = 1'b0; req_in = 8'h00; step();

    // Randomized traffic, with occasional resets and mask changes.
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) == 0) req_in[$urandom_range(0, 7)] ^= 1'b1;
      if ($urandom_range(0, 15) == 0) mask = 8'($urandom);
      irq_ack = ($urandom_range(0, 2) == 0);
      eoi     = ($urandom_range(0, 2) == 0);
      rst     = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
`default_nettype wire
